// File: rtl/dcache_arb.sv
// dcache_arb: arbiter/sequencer for the single data-cache command port.
//
// Two requesters share the port: load misses from the LSQ and retired
// stores from the store-queue head. Stores wait in a small circular
// committed-store buffer (CSB). Loads normally win, bounded by a starvation
// counter. A load whose address matches a buffered store is either parked in
// a 1-entry hold register until the store drains, or (with DCARB_STFWD_EN)
// answered directly from the youngest matching CSB entry.
//
// Optional feature macro: DCARB_STFWD_EN (store-to-load forwarding).
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-low reset
//   lsq_st_valid/addr/value      retired store offered; lsq_st_ack = ~csb_full
//   ld_req/addr/pr_idx/ar_idx    load offered; ld_avail says it is consumed
//   dc_cmd_ready                 cache accepts a command this cycle
//   dc_cmd_valid/wr/addr/wr_data/pr_idx/ar_idx   command to the Dcache
//   fwd_valid/pr_idx/ar_idx/value                forwarded load result
//   halt_req, drained            drain the CSB, block new loads
//   csb_full, csb_empty          buffer occupancy
module dcache_arb #(
    parameter int CSB_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsq_st_valid,
    input  logic [63:0] lsq_st_addr,
    input  logic [63:0] lsq_st_value,
    output logic        lsq_st_ack,
    input  logic        ld_req,
    input  logic [63:0] ld_addr,
    input  logic [6:0]  ld_pr_idx,
    input  logic [4:0]  ld_ar_idx,
    output logic        ld_avail,
    input  logic        dc_cmd_ready,
    output logic        dc_cmd_valid,
    output logic        dc_cmd_wr,
    output logic [63:0] dc_addr,
    output logic [63:0] dc_wr_data,
    output logic [6:0]  dc_pr_idx,
    output logic [4:0]  dc_ar_idx,
    output logic        fwd_valid,
    output logic [6:0]  fwd_pr_idx,
    output logic [4:0]  fwd_ar_idx,
    output logic [63:0] fwd_value,
    input  logic        halt_req,
    output logic        drained,
    output logic        csb_full,
    output logic        csb_empty
);
    localparam int PW = $clog2(CSB_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        LD_PRI = 2'd0,
        ST_PRI = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t        state;
    logic [63:0]   csb_addr [CSB_DEPTH];
    logic [63:0]   csb_data [CSB_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    logic [3:0]    starve_cnt;

    logic          hold_valid;
    logic [63:0]   hold_addr;
    logic [6:0]    hold_pr;
    logic [4:0]    hold_ar;

    logic [CSB_DEPTH-1:0] ld_hit, hold_hit;
    logic ld_conf, hold_conf, ld_take, enq, hold_set;
    logic iss_st, iss_hold, iss_ld;

    // Per-entry validity and address match. An entry is live when its
    // distance from head is below count. The store being enqueued this cycle
    // is not yet in the array, so it never takes part in the match.
    generate
        for (genvar i = 0; i < CSB_DEPTH; i++) begin : g_ent
            logic [PW-1:0] age;
            logic          live;
            assign age         = PW'(i) - head;
            assign live        = {1'b0, age} < count;
            assign ld_hit[i]   = live & (csb_addr[i] == ld_addr);
            assign hold_hit[i] = live & (csb_addr[i] == hold_addr);
        end
    endgenerate

    assign ld_conf   = |ld_hit;
    assign hold_conf = |hold_hit;

    assign csb_full   = (count == CW'(CSB_DEPTH));
    assign csb_empty  = (count == '0);
    assign lsq_st_ack = ~csb_full;
    assign ld_avail   = ~hold_valid & (state == LD_PRI) & dc_cmd_ready;
    assign drained    = (state == DRAIN) & csb_empty & ~hold_valid;

    assign ld_take = ld_req & ld_avail;
    assign enq     = lsq_st_valid & ~csb_full;

    // Port choice. A conflicting new load still owns the port for the cycle
    // it is accepted (it goes to hold/forward), so no store issues then.
    always_comb begin
        iss_st   = 1'b0;
        iss_hold = 1'b0;
        iss_ld   = 1'b0;
        if (dc_cmd_ready) begin
            if (hold_valid & ~hold_conf)
                iss_hold = 1'b1;
            else if (hold_valid)
                iss_st = 1'b1;
            else if (state != LD_PRI)
                iss_st = ~csb_empty;
            else if (ld_req)
                iss_ld = ~ld_conf;
            else
                iss_st = ~csb_empty;
        end
    end

    always_comb begin
        dc_cmd_valid = iss_st | iss_hold | iss_ld;
        dc_cmd_wr    = iss_st;
        dc_addr      = '0;
        dc_wr_data   = '0;
        dc_pr_idx    = '0;
        dc_ar_idx    = '0;
        if (iss_st) begin
            dc_addr    = csb_addr[head];
            dc_wr_data = csb_data[head];
        end else if (iss_hold) begin
            dc_addr   = hold_addr;
            dc_pr_idx = hold_pr;
            dc_ar_idx = hold_ar;
        end else if (iss_ld) begin
            dc_addr   = ld_addr;
            dc_pr_idx = ld_pr_idx;
            dc_ar_idx = ld_ar_idx;
        end
    end

    assign count_nxt = count + CW'(enq) - CW'(iss_st);

    // Store payload array: no reset needed, occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (enq) begin
            csb_addr[tail] <= lsq_st_addr;
            csb_data[tail] <= lsq_st_value;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= LD_PRI;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_pr    <= '0;
            hold_ar    <= '0;
        end else begin
            count <= count_nxt;
            if (enq)    tail <= tail + PW'(1);
            if (iss_st) head <= head + PW'(1);

            if (iss_hold) begin
                hold_valid <= 1'b0;
            end else if (hold_set) begin
                hold_valid <= 1'b1;
                hold_addr  <= ld_addr;
                hold_pr    <= ld_pr_idx;
                hold_ar    <= ld_ar_idx;
            end

            if (state != LD_PRI || iss_st)
                starve_cnt <= '0;
            else if (!csb_empty)
                starve_cnt <= starve_cnt + 4'd1;

            case (state)
                LD_PRI: begin
                    if (halt_req)
                        state <= DRAIN;
                    else if (csb_full ||
                             (!iss_st && !csb_empty &&
                              starve_cnt == 4'(STARVE_LIMIT - 1)))
                        state <= ST_PRI;
                end
                ST_PRI: begin
                    if (halt_req)
                        state <= DRAIN;
                    else if (iss_st && count_nxt != CW'(CSB_DEPTH))
                        state <= LD_PRI;
                end
                DRAIN: begin
                    if (!halt_req)
                        state <= LD_PRI;
                end
                default: state <= LD_PRI;
            endcase
        end
    end

`ifdef DCARB_STFWD_EN
    logic          fwd_take;
    logic [63:0]   fwd_sel;
    logic [PW-1:0] fwd_idx;

    assign hold_set = 1'b0;
    assign fwd_take = ld_take & ld_conf;

    // Walk from oldest to youngest; the last hit is the youngest store.
    always_comb begin
        fwd_sel = '0;
        fwd_idx = '0;
        for (int k = 0; k < CSB_DEPTH; k++) begin
            fwd_idx = head + PW'(k);
            if (ld_hit[fwd_idx])
                fwd_sel = csb_data[fwd_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fwd_valid  <= 1'b0;
            fwd_pr_idx <= '0;
            fwd_ar_idx <= '0;
            fwd_value  <= '0;
        end else begin
            fwd_valid <= fwd_take;
            if (fwd_take) begin
                fwd_pr_idx <= ld_pr_idx;
                fwd_ar_idx <= ld_ar_idx;
                fwd_value  <= fwd_sel;
            end
        end
    end
`else
    assign hold_set   = ld_take & ld_conf;
    assign fwd_valid  = 1'b0;
    assign fwd_pr_idx = '0;
    assign fwd_ar_idx = '0;
    assign fwd_value  = '0;
`endif

endmodule

// File: tb/tb_dcache_arb.sv
// Scoreboard bench for dcache_arb: a queue-based reference model predicts
// every cycle's flags and commands; a separate monitor compares.
module tb_dcache_arb;
    localparam int D   = 4;
    localparam int LIM = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        lsq_st_valid = 1'b0;
    logic [63:0] lsq_st_addr = '0, lsq_st_value = '0;
    logic        lsq_st_ack;
    logic        ld_req = 1'b0;
    logic [63:0] ld_addr = '0;
    logic [6:0]  ld_pr_idx = '0;
    logic [4:0]  ld_ar_idx = '0;
    logic        ld_avail;
    logic        dc_cmd_ready = 1'b0;
    logic        dc_cmd_valid, dc_cmd_wr;
    logic [63:0] dc_addr, dc_wr_data;
    logic [6:0]  dc_pr_idx;
    logic [4:0]  dc_ar_idx;
    logic        fwd_valid;
    logic [6:0]  fwd_pr_idx;
    logic [4:0]  fwd_ar_idx;
    logic [63:0] fwd_value;
    logic        halt_req = 1'b0;
    logic        drained, csb_full, csb_empty;

    dcache_arb #(.CSB_DEPTH(D), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .lsq_st_valid(lsq_st_valid), .lsq_st_addr(lsq_st_addr),
        .lsq_st_value(lsq_st_value), .lsq_st_ack(lsq_st_ack),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_pr_idx(ld_pr_idx),
        .ld_ar_idx(ld_ar_idx), .ld_avail(ld_avail),
        .dc_cmd_ready(dc_cmd_ready), .dc_cmd_valid(dc_cmd_valid),
        .dc_cmd_wr(dc_cmd_wr), .dc_addr(dc_addr), .dc_wr_data(dc_wr_data),
        .dc_pr_idx(dc_pr_idx), .dc_ar_idx(dc_ar_idx),
        .fwd_valid(fwd_valid), .fwd_pr_idx(fwd_pr_idx),
        .fwd_ar_idx(fwd_ar_idx), .fwd_value(fwd_value),
        .halt_req(halt_req), .drained(drained),
        .csb_full(csb_full), .csb_empty(csb_empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [6:0]  pr;
        logic [4:0]  ar;
    } cmd_t;

    typedef struct {
        bit ld_av, ack, full, empty, drn, vld, fwd;
    } flag_t;

    typedef struct {
        logic [6:0]  pr;
        logic [4:0]  ar;
        logic [63:0] val;
    } fwd_t;

    int checks = 0;
    int fails  = 0;

    // reference model state
    ent_t        mq[$];
    int          m_st;      // 0 load-priority, 1 store-priority, 2 drain
    int          m_sc;
    bit          m_hv;
    logic [63:0] m_ha;
    logic [6:0]  m_hpr;
    logic [4:0]  m_har;
    bit          m_fp;

    cmd_t  cq[$];
    flag_t flq[$];
    fwd_t  fwq[$];
    int    cyc_id = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [63:0] a);
        foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] youngest(input logic [63:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].addr == a) return mq[i].data;
        return '0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_st = 0; m_sc = 0; m_hv = 0; m_ha = '0; m_hpr = '0; m_har = '0; m_fp = 0;
    endtask

    task automatic model_step(input bit sv, input logic [63:0] sa, input logic [63:0] sd,
                              input bit lr, input logic [63:0] la, input logic [6:0] pr,
                              input logic [4:0] ar, input bit rdy, input bit hlt);
        flag_t f;
        cmd_t  c;
        fwd_t  w;
        bit full, empty, lav, lconf, hconf, ist, ihold, ild;
        int nst;
        full  = (mq.size() == D);
        empty = (mq.size() == 0);
        lav   = !m_hv && m_st == 0 && rdy;
        lconf = hit(la);
        hconf = m_hv && hit(m_ha);
        ist = 0; ihold = 0; ild = 0;
        if (rdy) begin
            if (m_hv && !hconf)  ihold = 1;
            else if (m_hv)       ist = 1;
            else if (m_st != 0)  ist = !empty;
            else if (lr)         ild = !lconf;
            else                 ist = !empty;
        end
        f.ld_av = lav; f.ack = !full; f.full = full; f.empty = empty;
        f.drn = (m_st == 2) && empty && !m_hv;
        f.vld = ist | ihold | ild;
        f.fwd = m_fp;
        flq.push_back(f);
        if (ist) begin
            c.wr = 1; c.addr = mq[0].addr; c.data = mq[0].data; c.pr = '0; c.ar = '0;
            cq.push_back(c);
        end else if (ihold) begin
            c.wr = 0; c.addr = m_ha; c.data = '0; c.pr = m_hpr; c.ar = m_har;
            cq.push_back(c);
        end else if (ild) begin
            c.wr = 0; c.addr = la; c.data = '0; c.pr = pr; c.ar = ar;
            cq.push_back(c);
        end
        // state update
        m_fp = 0;
        if (ihold) m_hv = 0;
        if (lr && lav && lconf) begin
`ifdef DCARB_STFWD_EN
            w.pr = pr; w.ar = ar; w.val = youngest(la);
            fwq.push_back(w);
            m_fp = 1;
`else
            m_hv = 1; m_ha = la; m_hpr = pr; m_har = ar;
`endif
        end
        if (ist) mq.delete(0);
        if (sv && !full) begin
            ent_t e;
            e.addr = sa; e.data = sd;
            mq.push_back(e);
        end
        nst = m_st;
        case (m_st)
            0: if (hlt) nst = 2;
               else if (full || (!ist && !empty && m_sc == LIM - 1)) nst = 1;
            1: if (hlt) nst = 2;
               else if (ist && mq.size() != D) nst = 0;
            default: if (!hlt) nst = 0;
        endcase
        if (m_st != 0 || ist) m_sc = 0;
        else if (!empty) m_sc++;
        m_st = nst;
    endtask

    task automatic cyc(input bit sv, input logic [63:0] sa, input logic [63:0] sd,
                       input bit lr, input logic [63:0] la, input logic [6:0] pr,
                       input logic [4:0] ar, input bit rdy, input bit hlt);
        @(negedge clock);
        reset = 1'b1;
        lsq_st_valid = sv; lsq_st_addr = sa; lsq_st_value = sd;
        ld_req = lr; ld_addr = la; ld_pr_idx = pr; ld_ar_idx = ar;
        dc_cmd_ready = rdy; halt_req = hlt;
        #1;
        model_step(sv, sa, sd, lr, la, pr, ar, rdy, hlt);
        cyc_id++;
    endtask

    task automatic rst_cyc();
        @(negedge clock);
        reset = 1'b0;
        lsq_st_valid = 0; ld_req = 0; dc_cmd_ready = 0; halt_req = 0;
        model_reset();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0, '0, rdy, 0);
    endtask

    // monitor: compares DUT outputs against whatever the model queued
    int seen = 0;
    always @(negedge clock) begin
        #2;
        if (seen != cyc_id) begin
            flag_t f;
            cmd_t  c;
            fwd_t  w;
            seen = cyc_id;
            if (flq.size() == 0) begin
                checks++; fails++;
                $display("FAIL flag_queue_empty t=%0t", $time);
            end else begin
                f = flq.pop_front();
                chk("ld_avail",     ld_avail,     64'(f.ld_av));
                chk("lsq_st_ack",   lsq_st_ack,   64'(f.ack));
                chk("csb_full",     csb_full,     64'(f.full));
                chk("csb_empty",    csb_empty,    64'(f.empty));
                chk("drained",      drained,      64'(f.drn));
                chk("dc_cmd_valid", dc_cmd_valid, 64'(f.vld));
                chk("fwd_valid",    fwd_valid,    64'(f.fwd));
            end
            if (dc_cmd_valid) begin
                if (cq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_cmd addr=%0h t=%0t", dc_addr, $time);
                end else begin
                    c = cq.pop_front();
                    chk("dc_cmd_wr",  dc_cmd_wr,  64'(c.wr));
                    chk("dc_addr",    dc_addr,    c.addr);
                    chk("dc_wr_data", dc_wr_data, c.data);
                    chk("dc_pr_idx",  dc_pr_idx,  64'(c.pr));
                    chk("dc_ar_idx",  dc_ar_idx,  64'(c.ar));
                end
            end
            if (fwd_valid) begin
                if (fwq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_fwd t=%0t", $time);
                end else begin
                    w = fwq.pop_front();
                    chk("fwd_value",  fwd_value,  w.val);
                    chk("fwd_pr_idx", fwd_pr_idx, 64'(w.pr));
                    chk("fwd_ar_idx", fwd_ar_idx, 64'(w.ar));
                end
            end
        end
    end

    initial begin
        bit hlt;
        model_reset();
        rst_cyc();
        rst_cyc();
        // first cycle out of reset, nothing offered, cache not ready
        cyc(0, '0, '0, 0, '0, '0, '0, 0, 0);
        chk("rst_csb_empty", csb_empty,    64'd1);
        chk("rst_st_ack",    lsq_st_ack,   64'd1);
        chk("rst_csb_full",  csb_full,     64'd0);
        chk("rst_cmd_valid", dc_cmd_valid, 64'd0);
        chk("rst_drained",   drained,      64'd0);
        chk("rst_fwd_valid", fwd_valid,    64'd0);

        // store drain, FIFO order
        for (int i = 0; i < 4; i++)
            cyc(1, 64'h100 + 64'(8 * i), 64'(i + 1), 0, '0, '0, '0, 0, 0);
        idle(6, 1);

        // full: fifth store refused, then store priority
        for (int i = 0; i < 5; i++)
            cyc(1, 64'h300 + 64'(8 * i), 64'(16 + i), 0, '0, '0, '0, 0, 0);
        cyc(0, '0, '0, 0, '0, '0, '0, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(0, '0, '0, 1, 64'h900, 7'(i), 5'(i), 1, 0);
        idle(6, 1);

        // starvation guard
        cyc(1, 64'h400, 64'h44, 0, '0, '0, '0, 0, 0);
        for (int i = 0; i < 12; i++)
            cyc(0, '0, '0, 1, 64'h908, 7'(20 + i), 5'(i), 1, 0);
        idle(3, 1);

        // address conflict
        cyc(1, 64'h200, 64'hAB, 0, '0, '0, '0, 0, 0);
        cyc(0, '0, '0, 1, 64'h200, 7'd5, 5'd3, 1, 0);
        idle(4, 1);

        // two stores to one address, then a matching load
        cyc(1, 64'h200, 64'h1, 0, '0, '0, '0, 0, 0);
        cyc(1, 64'h200, 64'h2, 0, '0, '0, '0, 0, 0);
        cyc(0, '0, '0, 1, 64'h200, 7'd9, 5'd7, 1, 0);
        idle(5, 1);

        // halt / drain with a load held high
        for (int i = 0; i < 3; i++)
            cyc(1, 64'h500 + 64'(8 * i), 64'(32 + i), 0, '0, '0, '0, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(0, '0, '0, 1, 64'h910, 7'(40 + i), 5'(i), 1, 1);
        for (int i = 0; i < 3; i++)
            cyc(0, '0, '0, 1, 64'h918, 7'(50 + i), 5'(i), 1, 0);

        // reset while stores are buffered
        cyc(1, 64'h600, 64'h66, 0, '0, '0, '0, 0, 0);
        cyc(1, 64'h608, 64'h67, 0, '0, '0, '0, 0, 0);
        rst_cyc();
        idle(3, 1);

        // randomized traffic over a small address pool
        hlt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 500) rst_cyc();
            if (!hlt && $urandom_range(0, 59) == 0) hlt = 1;
            else if (hlt && $urandom_range(0, 7) == 0) hlt = 0;
            cyc(1'($urandom_range(0, 1)),
                64'h100 + 64'(8 * $urandom_range(0, 5)), {$urandom, $urandom},
                ($urandom_range(0, 2) != 0),
                64'h100 + 64'(8 * $urandom_range(0, 5)),
                7'($urandom), 5'($urandom),
                ($urandom_range(0, 3) != 0), hlt);
        end
        idle(20, 1);

        @(negedge clock);
        #3;
        chk("cmd_queue_left", 64'(cq.size()),  64'd0);
        chk("fwd_queue_left", 64'(fwq.size()), 64'd0);
        chk("flag_queue_left", 64'(flq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
